// File: rtl/hram_pwr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hram_pwr_pkg
// Description : Shared state encodings and helpers for the HyperRAM power
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hram_pwr_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] RESET    = 3'd0;
    localparam logic [STATE_W-1:0] WAIT_VCS = 3'd1;
    localparam logic [STATE_W-1:0] HR_RESET = 3'd2;
    localparam logic [STATE_W-1:0] WAIT_RH  = 3'd3;
    localparam logic [STATE_W-1:0] READY    = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET    = RESET,
        ST_WAIT_VCS = WAIT_VCS,
        ST_HR_RESET = HR_RESET,
        ST_WAIT_RH  = WAIT_RH,
        ST_READY    = READY
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hram_power_sequencer_reset_sync.sv
`default_nettype none
// ============================================================================
// Module      : reset_sync
// Description : Asynchronous-assert, synchronous-deassert reset synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/hram_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hram_power_sequencer
// Description : HyperRAM power-up / warm re-init sequencer gating the system
//               reset released to the controller and CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module hram_power_sequencer
    import hram_pwr_pkg::*;
#(
    parameter int VCS_CYCLES  = 18750,
    parameter int RP_CYCLES   = 25,
    parameter int RH_CYCLES   = 25,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reinit_req,
    output logic               hram_rst_n,
    output logic               sys_rst_n,
    output logic               hram_ready,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int CNT_W = $clog2(max3(VCS_CYCLES, RP_CYCLES, RH_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] C_VCS_LOAD = CNT_W'(VCS_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RP_LOAD  = CNT_W'(RP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RH_LOAD  = CNT_W'(RH_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    logic             w_rst_sync_n;
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_hram_rst_n;
    logic             r_sys_rst_n;
    logic             r_hram_ready;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (w_rst_sync_n)
    );

    // Every timed state is entered with N-1 loaded and leaves when it hits 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RESET: begin
                w_cnt_nxt = '0;
                if (w_rst_sync_n) begin
                    w_state_nxt = ST_WAIT_VCS;
                    w_cnt_nxt   = C_VCS_LOAD;
                end
            end
            ST_WAIT_VCS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HR_RESET;
                    w_cnt_nxt   = C_RP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_HR_RESET: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WAIT_RH;
                    w_cnt_nxt   = C_RH_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_WAIT_RH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_READY: begin
                w_cnt_nxt = '0;
                if (reinit_req) begin
                    w_state_nxt = ST_HR_RESET;
                    w_cnt_nxt   = C_RP_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_dbg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RESET;
            r_cnt        <= '0;
            r_hram_rst_n <= 1'b0;
            r_sys_rst_n  <= 1'b0;
            r_hram_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hram_rst_n <= (w_state_nxt == ST_WAIT_RH) || (w_state_nxt == ST_READY);
            r_sys_rst_n  <= (w_state_nxt == ST_READY);
            r_hram_ready <= (w_state_nxt == ST_READY);
        end
    end

    assign hram_rst_n = r_hram_rst_n;
    assign sys_rst_n  = r_sys_rst_n;
    assign hram_ready = r_hram_ready;
    assign state_dbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hram_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hram_power_sequencer
// Description : Scoreboard bench for the HyperRAM power sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hram_power_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reinit_req;
    logic       reinit_c;
    logic       hram_rst_n, sys_rst_n, hram_ready;
    logic [2:0] state_dbg;
    logic       c_hram_rst_n, c_sys_rst_n, c_hram_ready;
    logic [2:0] c_state_dbg;

    logic [5:0] q_main[$];
    logic [5:0] q_corner[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    hram_power_sequencer #(
        .VCS_CYCLES (10), .RP_CYCLES (3), .RH_CYCLES (4), .SYNC_STAGES (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reinit_req (reinit_req),
        .hram_rst_n (hram_rst_n),
        .sys_rst_n  (sys_rst_n),
        .hram_ready (hram_ready),
        .state_dbg  (state_dbg)
    );

    hram_power_sequencer #(
        .VCS_CYCLES (1), .RP_CYCLES (1), .RH_CYCLES (1), .SYNC_STAGES (2)
    ) u_dut_corner (
        .clk        (clk),
        .rst_n      (rst_n),
        .reinit_req (reinit_c),
        .hram_rst_n (c_hram_rst_n),
        .sys_rst_n  (c_sys_rst_n),
        .hram_ready (c_hram_ready),
        .state_dbg  (c_state_dbg)
    );

    wire [5:0] w_obs_main   = {state_dbg, hram_rst_n, sys_rst_n, hram_ready};
    wire [5:0] w_obs_corner = {c_state_dbg, c_hram_rst_n, c_sys_rst_n, c_hram_ready};

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got {state,hram_rst_n,sys_rst_n,ready}=%b required %b",
                     tag, $time, obs, exp);
        end
    endtask

    function automatic logic [5:0] pk(input int st, input bit hr, input bit sr, input bit rdy);
        return {st[2:0], hr, sr, rdy};
    endfunction

    // Expected outputs n cycles after rst_n release (2-stage synchroniser).
    function automatic logic [5:0] cold_exp(input int n, input int vcs, input int rp, input int rh);
        int t1, t2, t3, t4;
        t1 = 2; t2 = t1 + vcs; t3 = t2 + rp; t4 = t3 + rh;
        if (n < t1)      return pk(0, 0, 0, 0);
        else if (n < t2) return pk(1, 0, 0, 0);
        else if (n < t3) return pk(2, 0, 0, 0);
        else if (n < t4) return pk(3, 1, 0, 0);
        else             return pk(4, 1, 1, 1);
    endfunction

    // Expected outputs k cycles after the cycle reinit_req is presented (k>=1).
    function automatic logic [5:0] warm_exp(input int k, input int rp, input int rh);
        if (k <= rp)           return pk(2, 0, 0, 0);
        else if (k <= rp + rh) return pk(3, 1, 0, 0);
        else                   return pk(4, 1, 1, 1);
    endfunction

    task automatic push_cold(input int cycles);
        for (int n = 0; n < cycles; n++) q_main.push_back(cold_exp(n, 10, 3, 4));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (q_main.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %b required an expected entry", tag, w_obs_main);
        end else begin
            check_eq(tag, w_obs_main, q_main.pop_front());
        end
        if (q_corner.size() != 0) check_eq("corner_1_1_1", w_obs_corner, q_corner.pop_front());
    endtask

    initial begin
        rst_n      = 1'b0;
        reinit_req = 1'b0;
        reinit_c   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", w_obs_main, 6'd0);
        check_eq("reset_state_corner", w_obs_corner, 6'd0);

        // Cold boot, with the all-ones parameter corner in parallel
        rst_n = 1'b1;
        push_cold(22);
        for (int n = 0; n < 22; n++) q_corner.push_back(cold_exp(n, 1, 1, 1));
        repeat (22) step("cold_boot");

        // Single-cycle warm re-init request
        reinit_req = 1'b1;
        for (int k = 1; k <= 8; k++) q_main.push_back(warm_exp(k, 3, 4));
        step("warm_reinit");
        reinit_req = 1'b0;
        repeat (7) step("warm_reinit");
        q_main.push_back(pk(4, 1, 1, 1));
        q_main.push_back(pk(4, 1, 1, 1));
        repeat (2) step("ready_hold");

        // reinit_req held high: READY for one cycle every 8
        reinit_req = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int k = 1; k <= 8; k++) q_main.push_back(warm_exp(k, 3, 4));
        repeat (24) step("held_reinit");
        reinit_req = 1'b0;
        q_main.push_back(pk(4, 1, 1, 1));
        step("held_release");

        // Sub-cycle rst_n glitch must clear everything asynchronously
        rst_n = 1'b0;
        #1;
        check_eq("glitch_async", w_obs_main, 6'd0);
        rst_n = 1'b1;

        // Requests in WAIT_VCS and WAIT_RH are ignored
        push_cold(22);
        for (int n = 0; n < 22; n++) begin
            reinit_req = (n == 6) || (n == 17);
            step("ignored_req");
        end
        reinit_req = 1'b0;

        // Reset asserted mid-sequence in HR_RESET
        rst_n = 1'b0;
        #1;
        check_eq("pre_mid_async", w_obs_main, 6'd0);
        rst_n = 1'b1;
        push_cold(14);
        repeat (14) step("pre_mid_rst");
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_async", w_obs_main, 6'd0);
        @(posedge clk);
        #1;
        check_eq("mid_rst_hold", w_obs_main, 6'd0);
        rst_n = 1'b1;
        push_cold(22);
        repeat (22) step("mid_rst_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
